llc_in_arbiter: RTL

// - Arbitrates the four LLC input channels (tb reset, coherence rsp, CPU req, DMA req) into one registered grant slot.
// - Feeds the LLC core DECODE stage and replaces its ad-hoc per-channel ready logic with one arbitration point.
// - Applies the core's stall masks so that stalled channels keep their data at the channel.
// - Fixed priority for reset/rsp; round-robin between req and DMA.

---
 rtl/llc_in_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/llc_in_arbiter.sv
// LLC input arbiter: merges tb reset, coherence rsp, CPU req and DMA req into one registered grant slot.
// Optional rsp starvation guard is compiled in when LLC_ARB_STARVE_EN is defined.
module llc_in_arbiter #(
   parameter int PAY_W = 64
`ifdef LLC_ARB_STARVE_EN
   ,
   parameter int STARVE_MAX = 4
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rst_tb_valid,
   output logic             rst_tb_ready,
   input  logic [PAY_W-1:0] rst_tb_data,
   input  logic             rsp_valid,
   output logic             rsp_ready,
   input  logic [PAY_W-1:0] rsp_data,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [PAY_W-1:0] req_data,
   input  logic             dma_valid,
   output logic             dma_ready,
   input  logic [PAY_W-1:0] dma_data,
   input  logic             req_stall,
   input  logic             dma_stall,
   input  logic             core_hold,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_src,
   output logic [PAY_W-1:0] out_data
);

   localparam logic [1:0] SRC_TB  = 2'd0;
   localparam logic [1:0] SRC_RSP = 2'd1;
   localparam logic [1:0] SRC_REQ = 2'd2;
   localparam logic [1:0] SRC_DMA = 2'd3;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

   state_e             state_q, state_d;
   logic [1:0]         out_src_q, out_src_d;
   logic [PAY_W-1:0]   out_data_q, out_data_d;
   logic               rr_dma_q, rr_dma_d;   // 1: dma preferred over req on a tie

   logic               elig_rsp, elig_req, elig_dma, any_elig;
   logic               slot_open, accept;
   logic [1:0]         win_src;
   logic [PAY_W-1:0]   win_data;

`ifdef LLC_ARB_STARVE_EN
   localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
`endif

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      elig_req = req_valid && !req_stall;
      elig_dma = dma_valid && !dma_stall;
      elig_rsp = rsp_valid;
`ifdef LLC_ARB_STARVE_EN
      if ((starve_cnt_q == CNT_W'(STARVE_MAX)) && (elig_req || elig_dma)) elig_rsp = 1'b0;
`endif
      any_elig = rst_tb_valid || elig_rsp || elig_req || elig_dma;

      win_src = SRC_TB;
      if (rst_tb_valid)             win_src = SRC_TB;
      else if (elig_rsp)            win_src = SRC_RSP;
      else if (elig_req && elig_dma) win_src = rr_dma_q ? SRC_DMA : SRC_REQ;
      else if (elig_req)            win_src = SRC_REQ;
      else if (elig_dma)            win_src = SRC_DMA;

      case (win_src)
         SRC_TB:  win_data = rst_tb_data;
         SRC_RSP: win_data = rsp_data;
         SRC_REQ: win_data = req_data;
         default: win_data = dma_data;
      endcase
   end

   // Readys are gated by rst so nothing is accepted while reset is held.
   assign slot_open    = ((state_q == EMPTY) || out_ready) && !core_hold;
   assign accept       = slot_open && any_elig && rst;
   assign rst_tb_ready = accept && (win_src == SRC_TB);
   assign rsp_ready    = accept && (win_src == SRC_RSP);
   assign req_ready    = accept && (win_src == SRC_REQ);
   assign dma_ready    = accept && (win_src == SRC_DMA);

   always_comb begin
      state_d    = state_q;
      out_src_d  = out_src_q;
      out_data_d = out_data_q;
      rr_dma_d   = rr_dma_q;
      case (state_q)
         EMPTY: if (accept) state_d = FULL;
         FULL:  if (out_ready && !accept) state_d = EMPTY;
      endcase
      if (accept) begin
         out_src_d  = win_src;
         out_data_d = win_data;
         if (win_src == SRC_REQ)      rr_dma_d = 1'b1;
         else if (win_src == SRC_DMA) rr_dma_d = 1'b0;
      end
   end

`ifdef LLC_ARB_STARVE_EN
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (accept) begin
         if (win_src == SRC_REQ || win_src == SRC_DMA)
            starve_cnt_d = '0;
         else if (win_src == SRC_RSP && (elig_req || elig_dma) &&
                  starve_cnt_q != CNT_W'(STARVE_MAX))
            starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) starve_cnt_q <= '0;
      else      starve_cnt_q <= starve_cnt_d;
   end
`endif

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= EMPTY;
         out_src_q  <= SRC_TB;
         out_data_q <= '0;
         rr_dma_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         out_src_q  <= out_src_d;
         out_data_q <= out_data_d;
         rr_dma_q   <= rr_dma_d;
      end
   end

   assign out_valid = (state_q == FULL);
   assign out_src   = out_src_q;
   assign out_data  = out_data_q;

endmodule
